// File: rtl/mpc_mul_pkg.sv
// Shared constants and types for the MPC shared-multiplier arbiter.
package mpc_mul_pkg;

   localparam int A_W      = 21;
   localparam int B_W      = 14;
   localparam int P_W      = A_W + B_W;
   localparam int MUL_LAT  = 3;
   localparam int TAG_W    = 4;
   localparam int NREQ_MAX = 8;

   // Slot id field is sized for the largest supported requester count.
   localparam int SLOT_ID_W = $clog2(NREQ_MAX);

   typedef struct packed {
      logic                 valid;
      logic [SLOT_ID_W-1:0] id;
      logic [TAG_W-1:0]     tag;
   } slot_t;

   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mpc_rr_arb.sv
// Combinational round-robin arbiter; search starts one past the pointer.
module mpc_rr_arb
   import mpc_mul_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic            en,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] id,
   output logic            found
);

   always_comb begin
      int idx;
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            id       = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mpc_mul_share_arb.sv
// Shares one pipelined signed DSP multiplier between NREQ requesters, routing
// each product back to its issuer through a tag pipeline that tracks the DSP.
module mpc_mul_share_arb
   import mpc_mul_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*A_W-1:0]   req_a,
   input  logic [NREQ*B_W-1:0]   req_b,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [P_W-1:0]        rsp_p,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic [A_W-1:0]        mul_a,
   output logic [B_W-1:0]        mul_b,
   output logic                  mul_ce,
   input  logic [P_W-1:0]        mul_p,
   output logic [2:0]            inflight
);

   localparam int ID_W = id_w(NREQ);

   slot_t           slot [MUL_LAT];
   slot_t           slot_in;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win_id;
   logic [NREQ-1:0] win_gnt;
   logic            win;
   logic            arb_en;
   logic            stall;
   logic            out_rdy;
   logic [2:0]      inflight_nxt;

   always_comb begin
      rsp_valid = '0;
      out_rdy   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (slot[MUL_LAT-1].id == SLOT_ID_W'(i)) begin
            rsp_valid[i] = slot[MUL_LAT-1].valid;
            out_rdy      = rsp_ready[i];
         end
      end
   end

   // A result nobody accepts freezes the DSP and the tag pipeline together.
   assign stall  = slot[MUL_LAT-1].valid && !out_rdy;
   assign mul_ce = !stall;
   assign arb_en = !stall && rst;

   mpc_rr_arb #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req   (req_valid),
      .en    (arb_en),
      .ptr   (ptr),
      .gnt   (win_gnt),
      .id    (win_id),
      .found (win)
   );

   assign req_ready = win_gnt;
   assign rsp_p     = mul_p;
   assign rsp_tag   = slot[MUL_LAT-1].tag;

   always_comb begin
      slot_in.valid = win;
      slot_in.id    = SLOT_ID_W'(win_id);
      slot_in.tag   = req_tag[int'(win_id)*TAG_W +: TAG_W];
      inflight_nxt  = 3'(win);
      for (int i = 0; i < MUL_LAT-1; i++) begin
         inflight_nxt = inflight_nxt + 3'(slot[i].valid);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            slot[i] <= '0;
         end
         ptr      <= ID_W'(NREQ-1);
         inflight <= '0;
      end else if (mul_ce) begin
         slot[0] <= slot_in;
         for (int i = 1; i < MUL_LAT; i++) begin
            slot[i] <= slot[i-1];
         end
         inflight <= inflight_nxt;
         if (win) begin
            ptr <= win_id;
         end
      end
   end

   // Operand registers count as the first DSP stage; bubbles leave them unchanged.
   always_ff @(posedge clk) begin
      if (win) begin
         mul_a <= req_a[int'(win_id)*A_W +: A_W];
         mul_b <= req_b[int'(win_id)*B_W +: B_W];
      end
   end

endmodule
